// File: rtl/uart_display_ctrl.sv
// Sequencing controller for the UART 7-segment display: digit scan, Rx/Tx view
// state machine with a timed peek at fresh Rx bytes, and the displayed data latches.
module uart_display_ctrl #(
    parameter int unsigned SCAN_DIV    = 100000,
    parameter int unsigned PEEK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode_btn,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    input  logic       tx_load,
    input  logic [7:0] tx_byte,
    output logic [7:0] Rx_Data,
    output logic [7:0] Tx_Data,
    output logic       Mode,
    output logic [1:0] Array,
    output logic       rx_new
);

    localparam int unsigned CW = $clog2(SCAN_DIV);
    localparam int unsigned KW = (PEEK_FRAMES > 1) ? $clog2(PEEK_FRAMES) : 1;
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
    localparam logic [KW-1:0] PEEK_LOAD = KW'(PEEK_FRAMES - 1);

    typedef enum logic [1:0] {
        RX_VIEW,
        TX_VIEW,
        PEEK
    } view_t;

    logic [CW-1:0] scan_cnt;
    logic          tick;
    logic          frame_end;

    logic          btn_s1;
    logic          btn_s2;
    logic          btn_s2_d;
    logic          btn_edge;

    view_t         state;
    logic [KW-1:0] peek_cnt;

    assign tick      = (scan_cnt == SCAN_LAST);
    assign frame_end = tick && (Array == 2'd3);

    // Free-running digit scan, independent of view state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            Array    <= '0;
        end else if (tick) begin
            scan_cnt <= '0;
            Array    <= Array + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + CW'(1);
        end
    end

    // Two-flop synchronizer followed by a registered rising-edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1   <= 1'b0;
            btn_s2   <= 1'b0;
            btn_s2_d <= 1'b0;
            btn_edge <= 1'b0;
        end else begin
            btn_s1   <= mode_btn;
            btn_s2   <= btn_s1;
            btn_s2_d <= btn_s2;
            btn_edge <= btn_s2 & ~btn_s2_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Rx_Data <= '0;
            Tx_Data <= '0;
        end else begin
            if (rx_valid) Rx_Data <= rx_byte;
            if (tx_load)  Tx_Data <= tx_byte;
        end
    end

    // rx_new is set by any rx_valid and cleared wherever the next state is RX_VIEW;
    // in RX_VIEW it is already 0, so only the stay-in-RX branch needs the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RX_VIEW;
            Mode     <= 1'b0;
            peek_cnt <= '0;
            rx_new   <= 1'b0;
        end else begin
            if (rx_valid) rx_new <= 1'b1;
            case (state)
                RX_VIEW: begin
                    if (btn_edge) begin
                        state <= TX_VIEW;
                        Mode  <= 1'b1;
                    end else begin
                        rx_new <= 1'b0;
                    end
                end
                TX_VIEW: begin
                    if (btn_edge) begin
                        state  <= RX_VIEW;
                        Mode   <= 1'b0;
                        rx_new <= 1'b0;
                    end else if (rx_valid) begin
                        state    <= PEEK;
                        Mode     <= 1'b0;
                        peek_cnt <= PEEK_LOAD;
                    end
                end
                PEEK: begin
                    if (btn_edge) begin
                        state <= TX_VIEW;
                        Mode  <= 1'b1;
                    end else if (rx_valid) begin
                        peek_cnt <= PEEK_LOAD;
                    end else if (frame_end) begin
                        if (peek_cnt == '0) begin
                            state <= TX_VIEW;
                            Mode  <= 1'b1;
                        end else begin
                            peek_cnt <= peek_cnt - KW'(1);
                        end
                    end
                end
                default: begin
                    state  <= RX_VIEW;
                    Mode   <= 1'b0;
                    rx_new <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_display_ctrl.sv
// Self-checking bench for uart_display_ctrl against a cycle-count based view model.
module tb_uart_display_ctrl;

    localparam int unsigned SD    = 4;
    localparam int unsigned PF    = 2;
    localparam int unsigned FRAME = 4 * SD;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       mode_btn = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte  = 8'h00;
    logic       tx_load  = 1'b0;
    logic [7:0] tx_byte  = 8'h00;
    logic [7:0] Rx_Data;
    logic [7:0] Tx_Data;
    logic       Mode;
    logic [1:0] Array;
    logic       rx_new;

    int checks   = 0;
    int failures = 0;

    // Reference model: edges since reset, button sample history, view and peek frames left.
    int unsigned m_n;
    int          m_view;   // 0 = Rx view, 1 = Tx view, 2 = peek
    int unsigned m_left;
    logic [7:0]  m_rx;
    logic [7:0]  m_tx;
    logic        m_rxnew;
    logic [3:0]  m_hist;
    logic        m_fe;

    uart_display_ctrl #(
        .SCAN_DIV   (SD),
        .PEEK_FRAMES(PF)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .mode_btn(mode_btn),
        .rx_valid(rx_valid),
        .rx_byte (rx_byte),
        .tx_load (tx_load),
        .tx_byte (tx_byte),
        .Rx_Data (Rx_Data),
        .Tx_Data (Tx_Data),
        .Mode    (Mode),
        .Array   (Array),
        .rx_new  (rx_new)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [1:0] exp_array();
        return 2'((m_n / SD) % 4);
    endfunction

    task automatic model_reset();
        m_n = 0; m_view = 0; m_left = 0; m_rx = 8'h00; m_tx = 8'h00;
        m_rxnew = 1'b0; m_hist = 4'b0000; m_fe = 1'b0;
    endtask

    task automatic model_edge();
        logic be;
        m_n++;
        m_fe = (m_n % FRAME) == 0;
        be = m_hist[2] & ~m_hist[3];
        m_hist = {m_hist[2:0], mode_btn};
        if (rx_valid) m_rx = rx_byte;
        if (tx_load)  m_tx = tx_byte;
        case (m_view)
            0: if (be) m_view = 1;
            1: begin
                if (be) m_view = 0;
                else if (rx_valid) begin m_view = 2; m_left = PF; end
            end
            default: begin
                if (be) m_view = 1;
                else if (rx_valid) m_left = PF;
                else if (m_fe) begin
                    m_left--;
                    if (m_left == 0) m_view = 1;
                end
            end
        endcase
        if (m_view == 0) m_rxnew = 1'b0;
        else if (rx_valid) m_rxnew = 1'b1;
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic press_btn();
        mode_btn = 1'b1;
        repeat (6) cyc();
        mode_btn = 1'b0;
        repeat (5) cyc();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mode_btn = 1'b0; rx_valid = 1'b0; tx_load = 1'b0;
        model_reset();
        #1;
        checks++; if (Mode !== 1'b0) begin failures++; $display("FAIL reset_mode got=%b exp=0", Mode); end
        checks++; if (Array !== 2'd0) begin failures++; $display("FAIL reset_array got=%0d exp=0", Array); end
        checks++; if (Rx_Data !== 8'h00) begin failures++; $display("FAIL reset_rx got=%h exp=00", Rx_Data); end
        checks++; if (Tx_Data !== 8'h00) begin failures++; $display("FAIL reset_tx got=%h exp=00", Tx_Data); end
        checks++; if (rx_new !== 1'b0) begin failures++; $display("FAIL reset_rxnew got=%b exp=0", rx_new); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_scan();
        logic [1:0] prev;
        int unsigned changes;
        prev = Array; changes = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            checks++;
            if (Array !== exp_array()) begin
                failures++;
                $display("FAIL scan_array edge=%0d got=%0d exp=%0d", m_n, Array, exp_array());
            end
            if (Array !== prev) changes++;
            prev = Array;
        end
        checks++; if (changes != 10) begin failures++; $display("FAIL scan_changes got=%0d exp=10", changes); end
    endtask

    task automatic test_rx_latch();
        rx_byte = 8'hA5; rx_valid = 1'b1;
        cyc();
        rx_valid = 1'b0;
        checks++; if (Rx_Data !== 8'hA5) begin failures++; $display("FAIL rxlatch_data got=%h exp=a5", Rx_Data); end
        checks++; if (Mode !== 1'b0) begin failures++; $display("FAIL rxlatch_mode got=%b exp=0", Mode); end
        checks++; if (rx_new !== 1'b0) begin failures++; $display("FAIL rxlatch_rxnew got=%b exp=0", rx_new); end
    endtask

    task automatic test_button();
        logic prev;
        int first, changes;
        mode_btn = 1'b0;
        repeat (5) cyc();
        for (int pass = 0; pass < 2; pass++) begin
            prev = Mode; first = 0; changes = 0;
            mode_btn = 1'b1;
            for (int k = 1; k <= 20; k++) begin
                cyc();
                if (Mode !== prev) begin
                    changes++;
                    if (first == 0) first = k;
                    prev = Mode;
                end
            end
            checks++; if (first != 4) begin failures++; $display("FAIL btn_latency pass=%0d got=%0d exp=4", pass, first); end
            checks++; if (changes != 1) begin failures++; $display("FAIL btn_single pass=%0d got=%0d exp=1", pass, changes); end
            checks++;
            if (Mode !== (pass == 0 ? 1'b1 : 1'b0)) begin
                failures++; $display("FAIL btn_mode pass=%0d got=%b exp=%0d", pass, Mode, pass == 0);
            end
            mode_btn = 1'b0;
            repeat (6) cyc();
        end
    endtask

    task automatic test_peek();
        int fes;
        bit done, on_fe;
        press_btn();
        checks++; if (Mode !== 1'b1) begin failures++; $display("FAIL peek_pre_mode got=%b exp=1", Mode); end
        rx_byte = 8'h3C; rx_valid = 1'b1;
        cyc();
        rx_valid = 1'b0;
        checks++; if (Mode !== 1'b0) begin failures++; $display("FAIL peek_enter_mode got=%b exp=0", Mode); end
        checks++; if (Rx_Data !== 8'h3C) begin failures++; $display("FAIL peek_rx got=%h exp=3c", Rx_Data); end
        checks++; if (rx_new !== 1'b1) begin failures++; $display("FAIL peek_rxnew got=%b exp=1", rx_new); end
        fes = 0; done = 0; on_fe = 0;
        for (int k = 0; k < 100 && !done; k++) begin
            cyc();
            if (m_fe) fes++;
            if (Mode === 1'b1) begin done = 1; on_fe = m_fe; end
        end
        checks++; if (!done || fes != PF || !on_fe) begin
            failures++; $display("FAIL peek_length done=%0d frame_ends=%0d exp=%0d on_frame_end=%0d", done, fes, PF, on_fe);
        end
        checks++; if (rx_new !== 1'b1) begin failures++; $display("FAIL peek_rxnew_hold got=%b exp=1", rx_new); end
        press_btn();
        checks++; if (Mode !== 1'b0) begin failures++; $display("FAIL peek_back_rx_mode got=%b exp=0", Mode); end
        checks++; if (rx_new !== 1'b0) begin failures++; $display("FAIL peek_rxnew_clear got=%b exp=0", rx_new); end
    endtask

    task automatic test_peek_extend();
        int fes;
        bit done, on_fe, seen;
        press_btn();
        rx_byte = 8'h11; rx_valid = 1'b1;
        cyc();
        rx_valid = 1'b0;
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            cyc();
            if (m_fe) seen = 1;
        end
        repeat (3) cyc();
        checks++; if (!seen || Mode !== 1'b0) begin failures++; $display("FAIL extend_mid got=%b exp=0 seen=%0d", Mode, seen); end
        rx_byte = 8'h22; rx_valid = 1'b1;
        cyc();
        rx_valid = 1'b0;
        fes = 0; done = 0; on_fe = 0;
        for (int k = 0; k < 100 && !done; k++) begin
            cyc();
            if (m_fe) fes++;
            if (Mode === 1'b1) begin done = 1; on_fe = m_fe; end
        end
        checks++; if (!done || fes != PF || !on_fe) begin
            failures++; $display("FAIL extend_length done=%0d frame_ends=%0d exp=%0d on_frame_end=%0d", done, fes, PF, on_fe);
        end
    endtask

    task automatic test_peek_abort();
        int k4;
        bit done;
        for (int k = 0; k < 40 && (m_n % FRAME) != 0; k++) cyc();
        rx_byte = 8'h44; rx_valid = 1'b1;
        cyc();
        rx_valid = 1'b0;
        checks++; if (Mode !== 1'b0) begin failures++; $display("FAIL abort_enter got=%b exp=0", Mode); end
        mode_btn = 1'b1;
        done = 0; k4 = 0;
        for (int k = 1; k <= 20 && !done; k++) begin
            cyc();
            if (Mode === 1'b1) begin done = 1; k4 = k; end
        end
        checks++; if (k4 != 4) begin failures++; $display("FAIL abort_latency got=%0d exp=4", k4); end
        checks++; if (rx_new !== 1'b1) begin failures++; $display("FAIL abort_rxnew got=%b exp=1", rx_new); end
        mode_btn = 1'b0;
        repeat (6) cyc();
    endtask

    task automatic test_btn_rx_coincide();
        checks++; if (Mode !== 1'b1) begin failures++; $display("FAIL coincide_pre got=%b exp=1", Mode); end
        mode_btn = 1'b1;
        repeat (3) cyc();
        rx_byte = 8'h5A; rx_valid = 1'b1;
        cyc();
        rx_valid = 1'b0;
        checks++; if (Mode !== 1'b0) begin failures++; $display("FAIL coincide_mode got=%b exp=0", Mode); end
        checks++; if (Rx_Data !== 8'h5A) begin failures++; $display("FAIL coincide_rx got=%h exp=5a", Rx_Data); end
        checks++; if (rx_new !== 1'b0) begin failures++; $display("FAIL coincide_rxnew got=%b exp=0", rx_new); end
        mode_btn = 1'b0;
        repeat (6) cyc();
    endtask

    task automatic test_simul_load();
        rx_byte = 8'h81; rx_valid = 1'b1;
        tx_byte = 8'h7E; tx_load = 1'b1;
        cyc();
        rx_valid = 1'b0; tx_load = 1'b0;
        checks++; if (Tx_Data !== 8'h7E) begin failures++; $display("FAIL simul_tx got=%h exp=7e", Tx_Data); end
        checks++; if (Rx_Data !== 8'h81) begin failures++; $display("FAIL simul_rx got=%h exp=81", Rx_Data); end
    endtask

    task automatic test_reset_mid_peek();
        press_btn();
        rx_byte = 8'h99; rx_valid = 1'b1;
        cyc();
        rx_valid = 1'b0;
        for (int k = 0; k < 8 && Array == 2'd0; k++) cyc();
        checks++; if (Array === 2'd0 || rx_new !== 1'b1) begin
            failures++; $display("FAIL midpeek_pre array=%0d rx_new=%b exp_nonzero_and_1", Array, rx_new);
        end
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++; if (Mode !== 1'b0) begin failures++; $display("FAIL midpeek_mode got=%b exp=0", Mode); end
        checks++; if (Array !== 2'd0) begin failures++; $display("FAIL midpeek_array got=%0d exp=0", Array); end
        checks++; if (rx_new !== 1'b0) begin failures++; $display("FAIL midpeek_rxnew got=%b exp=0", rx_new); end
        checks++; if (Rx_Data !== 8'h00) begin failures++; $display("FAIL midpeek_rx got=%h exp=00", Rx_Data); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        int hold;
        hold = 0;
        for (int i = 0; i < 900; i++) begin
            if (hold == 0) begin
                mode_btn = ~mode_btn;
                hold = int'($urandom_range(30, 4));
            end
            hold--;
            rx_valid = ($urandom_range(9, 0) == 0);
            rx_byte  = 8'($urandom);
            tx_load  = ($urandom_range(7, 0) == 0);
            tx_byte  = 8'($urandom);
            cyc();
            checks++; if (Mode !== (m_view == 1)) begin failures++; $display("FAIL rand_mode edge=%0d got=%b exp=%0d", m_n, Mode, m_view == 1); end
            checks++; if (Array !== exp_array()) begin failures++; $display("FAIL rand_array edge=%0d got=%0d exp=%0d", m_n, Array, exp_array()); end
            checks++; if (Rx_Data !== m_rx) begin failures++; $display("FAIL rand_rx edge=%0d got=%h exp=%h", m_n, Rx_Data, m_rx); end
            checks++; if (Tx_Data !== m_tx) begin failures++; $display("FAIL rand_tx edge=%0d got=%h exp=%h", m_n, Tx_Data, m_tx); end
            checks++; if (rx_new !== m_rxnew) begin failures++; $display("FAIL rand_rxnew edge=%0d got=%b exp=%b", m_n, rx_new, m_rxnew); end
        end
        rx_valid = 1'b0; tx_load = 1'b0; mode_btn = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_rx_latch();
        test_button();
        test_peek();
        test_peek_extend();
        test_peek_abort();
        test_btn_rx_coincide();
        test_simul_load();
        test_reset_mid_peek();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
